// File: rtl/conv_sequencer.sv
// Instruction sequencer for the weight-stationary convolution core: emits one registered
// 39-bit inst word per cycle covering weight/activation loads, execution, drain and SFU accumulation.
module conv_sequencer #(
    parameter int          col        = 8,
    parameter int          in_w       = 6,
    parameter int          k_w        = 3,
    parameter int          out_w      = in_w - k_w + 1,
    parameter logic [10:0] wt_base    = 11'h400,
    parameter int          gap_cycles = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [38:0] inst,
    output logic        acc_clr,
    output logic        out_valid,
    output logic [7:0]  out_idx,
    output logic        busy,
    output logic        done
);

    localparam int len_nij  = in_w * in_w;
    localparam int len_kij  = k_w * k_w;
    localparam int len_onij = out_w * out_w;

    localparam int t_max  = (3 * col > len_nij)
                          ? ((3 * col > gap_cycles) ? 3 * col : gap_cycles)
                          : ((len_nij > gap_cycles) ? len_nij : gap_cycles);
    localparam int t_bits = $clog2(t_max + 1);
    localparam int k_bits = $clog2(len_kij + 1);
    localparam int c_bits = $clog2(len_kij + 3);
    localparam int j_bits = $clog2(k_w + 1);
    localparam int o_bits = $clog2(out_w + 1);

    localparam logic [t_bits-1:0] t_one    = t_bits'(1);
    localparam logic [t_bits-1:0] wl0_last = t_bits'(col - 1);
    localparam logic [t_bits-1:0] wld_last = t_bits'(3 * col - 1);
    localparam logic [t_bits-1:0] gap_last = t_bits'(gap_cycles - 1);
    localparam logic [t_bits-1:0] nij_last = t_bits'(len_nij - 1);
    localparam logic [k_bits-1:0] kij_last = k_bits'(len_kij - 1);
    localparam logic [7:0]        onij_last = 8'(len_onij - 1);
    localparam logic [c_bits-1:0] c_one    = c_bits'(1);
    localparam logic [c_bits-1:0] c_two    = c_bits'(2);
    localparam logic [c_bits-1:0] c_rd_end = c_bits'(len_kij);
    localparam logic [c_bits-1:0] c_tail   = c_bits'(len_kij + 1);
    localparam logic [c_bits-1:0] c_out    = c_bits'(len_kij + 2);
    localparam logic [j_bits-1:0] kw_last  = j_bits'(k_w - 1);
    localparam logic [o_bits-1:0] ow_last  = o_bits'(out_w - 1);
    localparam logic [13:0]       nij_14   = 14'(len_nij);

    typedef enum logic [3:0] {
        S_IDLE, S_WL0, S_WLD, S_GAP, S_XL0, S_EXE, S_DRN, S_ACC, S_DONE
    } state_t;

    typedef struct packed {
        logic        sram_psum;
        logic        relu;
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [13:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    // Both memories disabled and in read mode; everything else quiet.
    localparam inst_t idle_word = inst_t'({5'b00011, 14'd0, 2'b11, 11'd0, 7'd0});

    state_t             state, state_n;
    logic [k_bits-1:0]  k_cnt, k_n;
    logic [t_bits-1:0]  t_cnt, t_n;
    logic [7:0]         o_cnt, o_n;
    logic [c_bits-1:0]  c_cnt, c_n;
    logic [j_bits-1:0]  jx, jx_n, jy, jy_n;
    logic [o_bits-1:0]  ox, ox_n, oy, oy_n;
    logic [13:0]        j_base, j_base_n;
    inst_t              inst_q, inst_n;
    logic               acc_clr_n, out_valid_n, busy_n, done_n;
    logic [7:0]         out_idx_n;

    assign inst = inst_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= S_IDLE;
            k_cnt     <= '0;
            t_cnt     <= '0;
            o_cnt     <= '0;
            c_cnt     <= '0;
            jx        <= '0;
            jy        <= '0;
            ox        <= '0;
            oy        <= '0;
            j_base    <= '0;
            inst_q    <= idle_word;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            k_cnt     <= k_n;
            t_cnt     <= t_n;
            o_cnt     <= o_n;
            c_cnt     <= c_n;
            jx        <= jx_n;
            jy        <= jy_n;
            ox        <= ox_n;
            oy        <= oy_n;
            j_base    <= j_base_n;
            inst_q    <= inst_n;
            acc_clr   <= acc_clr_n;
            out_valid <= out_valid_n;
            out_idx   <= out_idx_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_n     = state;
        k_n         = k_cnt;
        t_n         = t_cnt;
        o_n         = o_cnt;
        c_n         = c_cnt;
        jx_n        = jx;
        jy_n        = jy;
        ox_n        = ox;
        oy_n        = oy;
        j_base_n    = j_base;
        inst_n      = idle_word;
        acc_clr_n   = 1'b0;
        out_valid_n = 1'b0;
        out_idx_n   = '0;
        done_n      = 1'b0;
        busy_n      = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WL0;
                    k_n     = '0;
                    t_n     = '0;
                end
            end
            S_WL0: begin
                inst_n.cen_xmem = 1'b0;
                inst_n.a_xmem   = wt_base + 11'(k_cnt) * 11'(col) + 11'(t_cnt);
                inst_n.l0_wr    = 1'b1;
                if (t_cnt == wl0_last) begin
                    t_n     = '0;
                    state_n = S_WLD;
                end else t_n = t_cnt + t_one;
            end
            S_WLD: begin
                inst_n.l0_rd = 1'b1;
                inst_n.load  = 1'b1;
                if (t_cnt == wld_last) begin
                    t_n     = '0;
                    state_n = S_GAP;
                end else t_n = t_cnt + t_one;
            end
            S_GAP: begin
                if (t_cnt == gap_last) begin
                    t_n     = '0;
                    state_n = S_XL0;
                end else t_n = t_cnt + t_one;
            end
            S_XL0: begin
                inst_n.cen_xmem = 1'b0;
                inst_n.a_xmem   = 11'(t_cnt);
                inst_n.l0_wr    = 1'b1;
                if (t_cnt == nij_last) begin
                    t_n     = '0;
                    state_n = S_EXE;
                end else t_n = t_cnt + t_one;
            end
            S_EXE: begin
                inst_n.l0_rd   = 1'b1;
                inst_n.load    = 1'b1;
                inst_n.execute = 1'b1;
                if (t_cnt == nij_last) begin
                    t_n     = '0;
                    state_n = S_DRN;
                end else t_n = t_cnt + t_one;
            end
            S_DRN: begin
                // t_cnt doubles as the drain row index; a low ofifo_valid simply holds it.
                if (ofifo_valid) begin
                    inst_n.ofifo_rd = 1'b1;
                    inst_n.cen_pmem = 1'b0;
                    inst_n.wen_pmem = 1'b0;
                    inst_n.a_pmem   = 14'(k_cnt) * nij_14 + 14'(t_cnt);
                    if (t_cnt == nij_last) begin
                        t_n = '0;
                        if (k_cnt == kij_last) begin
                            state_n  = S_ACC;
                            o_n      = '0;
                            c_n      = '0;
                            ox_n     = '0;
                            oy_n     = '0;
                            jx_n     = '0;
                            jy_n     = '0;
                            j_base_n = '0;
                        end else begin
                            k_n     = k_cnt + k_bits'(1);
                            state_n = S_WL0;
                        end
                    end else t_n = t_cnt + t_one;
                end
            end
            S_ACC: begin
                out_idx_n = o_cnt;
                if (c_cnt == '0) acc_clr_n = 1'b1;
                if (c_cnt >= c_one && c_cnt <= c_rd_end) begin
                    inst_n.cen_pmem  = 1'b0;
                    inst_n.sram_psum = 1'b1;
                    inst_n.a_pmem    = j_base + (14'(oy) + 14'(jy)) * 14'(in_w) + 14'(ox) + 14'(jx);
                    j_base_n         = j_base + nij_14;
                    if (jx == kw_last) begin
                        jx_n = '0;
                        jy_n = jy + j_bits'(1);
                    end else jx_n = jx + j_bits'(1);
                end
                // Accumulate lags the read by one cycle to line up with pmem read data.
                if (c_cnt >= c_two && c_cnt <= c_tail) inst_n.acc = 1'b1;
                if (c_cnt == c_out) begin
                    out_valid_n = 1'b1;
                    c_n         = '0;
                    jx_n        = '0;
                    jy_n        = '0;
                    j_base_n    = '0;
                    if (o_cnt == onij_last) state_n = S_DONE;
                    else begin
                        o_n = o_cnt + 8'd1;
                        if (ox == ow_last) begin
                            ox_n = '0;
                            oy_n = oy + o_bits'(1);
                        end else ox_n = ox + o_bits'(1);
                    end
                end else c_n = c_cnt + c_one;
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: an expected per-cycle trace is built from the
// layer schedule with plain loops and compared edge by edge against the DUT outputs.
module tb_conv_sequencer;

    localparam int COL      = 8;
    localparam int IN_W     = 6;
    localparam int K_W      = 3;
    localparam int OUT_W    = 4;
    localparam int GAP      = 10;
    localparam int LEN_NIJ  = 36;
    localparam int LEN_KIJ  = 9;
    localparam int LEN_ONIJ = 16;
    localparam logic [10:0] WT_BASE = 11'h400;

    typedef struct packed {
        logic [38:0] inst;
        logic        acc_clr;
        logic        out_valid;
        logic [7:0]  out_idx;
        logic        done;
        logic        busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [38:0] inst;
    logic        acc_clr;
    logic        out_valid;
    logic [7:0]  out_idx;
    logic        busy;
    logic        done;

    conv_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .acc_clr     (acc_clr),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];
    bit   vpat[0:4095];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [38:0] idle_word();
        logic [38:0] w;
        w     = '0;
        w[35] = 1'b1;  // CEN_pmem
        w[34] = 1'b1;  // WEN_pmem
        w[19] = 1'b1;  // CEN_xmem
        w[18] = 1'b1;  // WEN_xmem
        return w;
    endfunction

    function automatic void push(input logic [38:0] w, input logic clr, input logic ov,
                                 input int idx, input logic dn);
        exp_q.push_back({w, clr, ov, 8'(idx), dn, 1'b1});
    endfunction

    function automatic obs_t sample(input logic idx_live);
        return {inst, acc_clr, out_valid, (idx_live ? out_idx : 8'h00), done, busy};
    endfunction

    // Expected outputs for edges 1..N after start is sampled; entry n-1 belongs to edge n.
    task automatic build_layer();
        logic [38:0] w;
        int p, n, oy, ox;
        exp_q.delete();
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int t = 0; t < COL; t++) begin
                w = idle_word(); w[19] = 1'b0; w[17:7] = WT_BASE + 11'(k * COL + t); w[2] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            for (int t = 0; t < 3 * COL; t++) begin
                w = idle_word(); w[3] = 1'b1; w[0] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            for (int t = 0; t < GAP; t++) push(idle_word(), 0, 0, 0, 0);
            for (int t = 0; t < LEN_NIJ; t++) begin
                w = idle_word(); w[19] = 1'b0; w[17:7] = 11'(t); w[2] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            for (int t = 0; t < LEN_NIJ; t++) begin
                w = idle_word(); w[3] = 1'b1; w[1] = 1'b1; w[0] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            p = 0;
            while (p < LEN_NIJ) begin
                n = exp_q.size() + 1;
                w = idle_word();
                if (vpat[n]) begin
                    w[6] = 1'b1; w[35] = 1'b0; w[34] = 1'b0; w[33:20] = 14'(k * LEN_NIJ + p);
                    p++;
                end
                push(w, 0, 0, 0, 0);
            end
        end
        for (int o = 0; o < LEN_ONIJ; o++) begin
            oy = o / OUT_W;
            ox = o % OUT_W;
            push(idle_word(), 1, 0, 0, 0);
            for (int c = 1; c <= LEN_KIJ + 1; c++) begin
                w = idle_word();
                if (c <= LEN_KIJ) begin
                    int j;
                    j = c - 1;
                    w[38] = 1'b1; w[35] = 1'b0;
                    w[33:20] = 14'(j * LEN_NIJ + (oy + j / K_W) * IN_W + ox + j % K_W);
                end
                if (c >= 2) w[36] = 1'b1;
                push(w, 0, 0, 0, 0);
            end
            push(idle_word(), 0, 1, o, 0);
        end
        push(idle_word(), 0, 0, 0, 1);
    endtask

    task automatic idle_cycles(input int count);
        for (int i = 0; i < count; i++) begin
            start       = 1'b0;
            ofifo_valid = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            check("idle", sample(1'b1), {idle_word(), 12'h000});
        end
    endtask

    // mode 0: ofifo_valid always high; 1: random; 2: 5-cycle stall at kij0 p=10.
    // ign_edge: edge at which a spurious start is sampled (0 = none).
    // abort_edge: stop checking after this edge (0 = run to done); exp_len < 0 uses the model length.
    task automatic run_layer(input int mode, input int ign_edge, input int abort_edge, input int exp_len);
        obs_t obs;
        int   done_edge;
        for (int i = 0; i < 4096; i++) begin
            case (mode)
                0:       vpat[i] = 1'b1;
                1:       vpat[i] = (i >= 3000) ? 1'b1 : ($urandom_range(3, 0) != 0);
                default: vpat[i] = !(i >= 125 && i <= 129);
            endcase
        end
        build_layer();
        start       = 1'b1;
        ofifo_valid = vpat[0];
        @(posedge clk); #1;
        check("pre_start_idle", sample(1'b1), {idle_word(), 12'h000});
        done_edge = 0;
        for (int n = 1; n <= exp_q.size(); n++) begin
            start       = (n == ign_edge);
            ofifo_valid = vpat[n];
            @(posedge clk); #1;
            obs = sample(exp_q[n-1].out_valid);
            check($sformatf("trace_edge%0d", n), obs, exp_q[n-1]);
            if (done === 1'b1 && done_edge == 0) done_edge = n;
            if (n == abort_edge) break;
        end
        start = 1'b0;
        if (abort_edge == 0)
            check("done_cycle", done_edge, (exp_len < 0) ? exp_q.size() : exp_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", sample(1'b1), {idle_word(), 12'h000});
        reset = 1'b0;
        idle_cycles(2);

        run_layer(0, 0, 0, 1543);   // nominal, ofifo_valid held high
        idle_cycles(3);
        run_layer(2, 0, 0, 1548);   // drain stall at p=10
        idle_cycles(2);
        run_layer(0, 36, 0, 1543);  // start pulsed during GAP is ignored
        idle_cycles(2);
        run_layer(1, 0, 0, -1);     // random ofifo_valid everywhere
        idle_cycles(1);
        run_layer(0, 0, 0, 1543);   // back-to-back pair
        run_layer(0, 0, 0, 1543);

        run_layer(0, 0, 100, 0);    // abandon mid-EXE with reset
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_mid_exe", sample(1'b1), {idle_word(), 12'h000});
        end
        reset = 1'b0;
        idle_cycles(2);
        run_layer(0, 0, 0, 1543);
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
